// File: rtl/mips_regfile_sb_if.sv
// Read/issue/writeback bundle for the pipelined MIPS register file.
// Master is the decode/writeback side, slave is the register file.
interface mips_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] read_reg_1;
    logic [ADDR_W-1:0] read_reg_2;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              busy_1;
    logic              busy_2;
    logic              signal_reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_set_reg;
    logic              busy_any;

    modport master (
        output read_reg_1, read_reg_2,
        output signal_reg_write, write_reg, write_data,
        output busy_set, busy_set_reg,
        input  read_data_1, read_data_2,
        input  busy_1, busy_2, busy_any
    );

    modport slave (
        input  read_reg_1, read_reg_2,
        input  signal_reg_write, write_reg, write_data,
        input  busy_set, busy_set_reg,
        output read_data_1, read_data_2,
        output busy_1, busy_2, busy_any
    );
endinterface

// File: rtl/mips_regfile_sb.sv
// Two registered read ports, one write port, per-register busy scoreboard.
// Busy bits let decode stall on outstanding multi-cycle results.
module mips_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_regfile_sb_if.slave  rf
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic              b1_q, b1_d;
    logic              b2_q, b2_d;
    logic              any_q, any_d;
    logic              wr_en, set_en;

    // Out-of-range and hardwired-zero addresses behave as a read-only zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < DEPTH_L);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W-1:0];
    endfunction

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        wr_en  = rf.signal_reg_write && addr_ok(rf.write_reg);
        set_en = rf.busy_set && addr_ok(rf.busy_set_reg);
        if (wr_en) begin
            regs_d[idx(rf.write_reg)] = rf.write_data;
            busy_d[idx(rf.write_reg)] = 1'b0;
        end
        // Applied after the clear so a same-register set wins.
        if (set_en) begin
            busy_d[idx(rf.busy_set_reg)] = 1'b1;
        end

        rd1_d = '0;
        b1_d  = 1'b0;
        if (addr_ok(rf.read_reg_1)) begin
            if (BYPASS != 0) begin
                rd1_d = regs_d[idx(rf.read_reg_1)];
                b1_d  = busy_d[idx(rf.read_reg_1)];
            end else begin
                rd1_d = regs_q[idx(rf.read_reg_1)];
                b1_d  = busy_q[idx(rf.read_reg_1)];
            end
        end

        rd2_d = '0;
        b2_d  = 1'b0;
        if (addr_ok(rf.read_reg_2)) begin
            if (BYPASS != 0) begin
                rd2_d = regs_d[idx(rf.read_reg_2)];
                b2_d  = busy_d[idx(rf.read_reg_2)];
            end else begin
                rd2_d = regs_q[idx(rf.read_reg_2)];
                b2_d  = busy_q[idx(rf.read_reg_2)];
            end
        end

        any_d = |busy_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            b1_q   <= 1'b0;
            b2_q   <= 1'b0;
            any_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
            b1_q   <= b1_d;
            b2_q   <= b2_d;
            any_q  <= any_d;
        end
    end

    assign rf.read_data_1 = rd1_q;
    assign rf.read_data_2 = rd2_q;
    assign rf.busy_1      = b1_q;
    assign rf.busy_2      = b2_q;
    assign rf.busy_any    = any_q;
endmodule

// File: tb/tb_mips_regfile_sb.sv
// Directed vector bench: default DUT, a read-first DUT and a 16-deep DUT
// share one stimulus stream; each is checked against hand-computed values.
module tb_mips_regfile_sb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rr1, rr2, wr, bsr;
    logic [31:0] wd;
    logic        we, bs;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifb ();
    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifc ();

    assign ifa.read_reg_1 = rr1;
    assign ifa.read_reg_2 = rr2;
    assign ifa.signal_reg_write = we;
    assign ifa.write_reg = wr;
    assign ifa.write_data = wd;
    assign ifa.busy_set = bs;
    assign ifa.busy_set_reg = bsr;

    assign ifb.read_reg_1 = rr1;
    assign ifb.read_reg_2 = rr2;
    assign ifb.signal_reg_write = we;
    assign ifb.write_reg = wr;
    assign ifb.write_data = wd;
    assign ifb.busy_set = bs;
    assign ifb.busy_set_reg = bsr;

    assign ifc.read_reg_1 = rr1;
    assign ifc.read_reg_2 = rr2;
    assign ifc.signal_reg_write = we;
    assign ifc.write_reg = wr;
    assign ifc.write_data = wd;
    assign ifc.busy_set = bs;
    assign ifc.busy_set_reg = bsr;

    mips_regfile_sb dut_a (.clk(clk), .rst_n(rst_n), .rf(ifa));

    mips_regfile_sb #(.BYPASS(0)) dut_b (.clk(clk), .rst_n(rst_n), .rf(ifb));

    mips_regfile_sb #(.DEPTH(16)) dut_c (.clk(clk), .rst_n(rst_n), .rf(ifc));

    typedef struct {
        bit          rst_n;
        bit          we;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          bs;
        logic [4:0]  bsr;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic [31:0] a_rd1;
        logic [31:0] a_rd2;
        bit          a_b1;
        bit          a_b2;
        bit          a_any;
        logic [31:0] b_rd1;
        logic [31:0] b_rd2;
        bit          b_b1;
        bit          b_any;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst we wr wd bs bsr rr1 rr2 | A rd1 rd2 b1 b2 any | B rd1 rd2 b1 any
        vecs[0]  = '{0,1,3,32'hDEADBEEF,0,0,3,0, 0,0,0,0,0, 0,0,0,0};
        vecs[1]  = '{0,1,3,32'hDEADBEEF,0,0,3,0, 0,0,0,0,0, 0,0,0,0};
        vecs[2]  = '{1,0,3,0,0,0,3,0, 0,0,0,0,0, 0,0,0,0};
        vecs[3]  = '{1,1,5,32'h12345678,0,0,3,0, 0,0,0,0,0, 0,0,0,0};
        vecs[4]  = '{1,0,5,0,0,0,5,5, 32'h12345678,32'h12345678,0,0,0,
                     32'h12345678,32'h12345678,0,0};
        vecs[5]  = '{1,1,7,32'hA5A5A5A5,0,0,5,7,
                     32'h12345678,32'hA5A5A5A5,0,0,0,
                     32'h12345678,0,0,0};
        vecs[6]  = '{1,1,7,32'h11111111,0,0,7,7,
                     32'h11111111,32'h11111111,0,0,0,
                     32'hA5A5A5A5,32'hA5A5A5A5,0,0};
        vecs[7]  = '{1,1,0,32'hFFFFFFFF,1,0,0,7,
                     0,32'h11111111,0,0,0, 0,32'h11111111,0,0};
        vecs[8]  = '{1,0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0};
        vecs[9]  = '{1,0,0,0,1,9,9,9, 0,0,1,1,1, 0,0,0,1};
        vecs[10] = '{1,1,9,32'h42,1,9,9,9, 32'h42,32'h42,1,1,1, 0,0,1,1};
        vecs[11] = '{1,1,9,32'h42,0,0,9,9, 32'h42,32'h42,0,0,0,
                     32'h42,32'h42,1,0};
        vecs[12] = '{1,0,0,0,0,0,9,5, 32'h42,32'h12345678,0,0,0,
                     32'h42,32'h12345678,0,0};
        vecs[13] = '{1,1,5,32'h55,1,6,5,6, 32'h55,0,0,1,1,
                     32'h12345678,0,0,1};
        vecs[14] = '{1,0,0,0,0,0,6,6, 0,0,1,1,1, 0,0,1,1};
        vecs[15] = '{0,1,6,32'h77,1,8,6,5, 0,0,0,0,0, 0,0,0,0};
        vecs[16] = '{1,0,0,0,0,0,6,5, 0,0,0,0,0, 0,0,0,0};

        rst_n = 1'b0;
        we = 0; wr = 0; wd = 0; bs = 0; bsr = 0; rr1 = 0; rr2 = 0;

        for (int i = 0; i < 17; i++) begin
            rst_n = vecs[i].rst_n;
            we    = vecs[i].we;
            wr    = vecs[i].wr;
            wd    = vecs[i].wd;
            bs    = vecs[i].bs;
            bsr   = vecs[i].bsr;
            rr1   = vecs[i].rr1;
            rr2   = vecs[i].rr2;
            step();
            chk($sformatf("v%0d a_rd1", i), ifa.read_data_1, vecs[i].a_rd1);
            chk($sformatf("v%0d a_rd2", i), ifa.read_data_2, vecs[i].a_rd2);
            chk($sformatf("v%0d a_b1", i), 32'(ifa.busy_1), 32'(vecs[i].a_b1));
            chk($sformatf("v%0d a_b2", i), 32'(ifa.busy_2), 32'(vecs[i].a_b2));
            chk($sformatf("v%0d a_any", i), 32'(ifa.busy_any),
                32'(vecs[i].a_any));
            chk($sformatf("v%0d b_rd1", i), ifb.read_data_1, vecs[i].b_rd1);
            chk($sformatf("v%0d b_rd2", i), ifb.read_data_2, vecs[i].b_rd2);
            chk($sformatf("v%0d b_b1", i), 32'(ifb.busy_1), 32'(vecs[i].b_b1));
            chk($sformatf("v%0d b_any", i), 32'(ifb.busy_any),
                32'(vecs[i].b_any));
        end

        // Out of range on the 16-deep instance: write and busy_set reg 20.
        // Reg 20 aliases reg 4 in the low index bits, so read both.
        we = 1; wr = 20; wd = 32'h1; bs = 1; bsr = 20; rr1 = 20; rr2 = 4;
        step();
        chk("c oor rd1", ifc.read_data_1, 32'h0);
        chk("c oor rd2", ifc.read_data_2, 32'h0);
        chk("c oor b1", 32'(ifc.busy_1), 32'h0);
        chk("c oor any", 32'(ifc.busy_any), 32'h0);
        chk("a reg20 rd1", ifa.read_data_1, 32'h1);
        chk("a reg20 b1", 32'(ifa.busy_1), 32'h1);

        we = 0; bs = 0;
        for (int r = 0; r < 16; r++) begin
            rr1 = 5'(r);
            rr2 = 5'(r) + 5'd16;
            step();
            chk($sformatf("c sweep r%0d", r), ifc.read_data_1, 32'h0);
            chk($sformatf("c sweep b%0d", r), 32'(ifc.busy_1), 32'h0);
            chk($sformatf("c hi r%0d", r + 16), ifc.read_data_2, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
